riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between the core's memory-stage request and the data memory. Accepts one aligned byte, halfword or word access at a time, drives the data memory's byte-enabled read/write strobes until acknowledged, and returns sign- or zero-extended load data with an error flag. A watchdog counter bounds every memory transaction. The core stalls its memory stage while `req_ready` is low.

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles a memory strobe is held without `mem_ack` before the access is aborted with error; legal range 2..255.
- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: core presents an access.
- `req_ready` out 1: unit can accept; transfer when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte, 1 halfword, 2 word; 3 is illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for byte).
- `resp_valid` out 1: one-cycle pulse, access complete.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; misalign, illegal size or timeout.
- `mem_addr` out 32: word address (`req_addr` with [1:0] = 0).
- `mem_wdata` out 32: store data replicated into byte lanes.
- `mem_be` out 4: byte enables.
- `mem_write` out 1: write strobe.
- `mem_read` out 1: read strobe.
- `mem_rdata` in 32: read word, sampled in the cycle `mem_ack` is high.
- `mem_ack` in 1: memory completes the strobed access.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready` = 1. On handshake, latch all req fields. Legal → ACCESS; illegal (size 3, or misaligned, see Configuration) → RESP with error, no memory strobe.
- ACCESS: `mem_read` = !we, `mem_write` = we, `mem_addr`/`mem_be`/`mem_wdata` stable from latched fields. `mem_ack` → RESP, capturing `mem_rdata`. Counter increments each ACCESS cycle; reaching `TIMEOUT_CYCLES` without ack → RESP with `resp_err` = 1, strobes drop.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE. `req_ready` = 0 in ACCESS and RESP (no back-to-back overlap).
- Byte enables: byte → `4'b0001 << addr[1:0]`; halfword → `4'b0011 << addr[1:0]`; word → `4'b1111`.
- `mem_wdata`: byte → {4{wdata[7:0]}}; halfword → {2{wdata[15:0]}}; word → wdata.
- Load extract: shift `mem_rdata` right by 8*addr[1:0], then extend bit 7 (byte) or bit 15 (half) unless `req_unsigned`.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset: state IDLE, counter 0, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_read` 0, `mem_write` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0.
- Handshake cycle N; strobe asserted N+1; ack in cycle N+k (k≥1) → `resp_valid` in N+k+1; `req_ready` high again N+k+2. Zero-wait memory (ack first strobe cycle): 3-cycle occupancy.
- Illegal request: `resp_valid` with error in N+1, no strobe ever asserted.
- Timeout: strobes high for exactly `TIMEOUT_CYCLES` cycles, `resp_valid`/`resp_err` the following cycle.
- Ack arriving in the same cycle the counter reaches the limit: ack wins, no error.
- Reset asserted mid-access: all outputs to reset values immediately (asynchronous); in-flight access dropped without response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: halfword with addr[0]=1 or word with addr[1:0]≠0 is illegal → error response, no strobe.
- Undefined: misaligned accesses are silently aligned (low address bits ignored for the access size: halfword uses addr[1] only, word uses lane 0) and complete normally without error.

## Test plan
- Word store 0xDEADBEEF to 0x100, ack on first strobe cycle → `mem_be`=4'b1111, `mem_write` one cycle, `resp_valid` at N+2, `resp_err`=0.
- Signed byte load from 0x103, `mem_rdata`=0x80112233 → `mem_be`=4'b1000, `resp_rdata`=0xFFFFFF80; unsigned same → 0x00000080.
- Halfword store 0x1234 to 0x202 → `mem_be`=4'b1100, `mem_wdata`=0x12341234; ack after 3 wait cycles → `resp_valid` at N+5.
- No ack with `TIMEOUT_CYCLES`=16 → strobe held 16 cycles, `resp_err`=1, `resp_rdata`=0, `req_ready` returns.
- Word load at 0x102: with macro → error at N+1, no strobe; without → `mem_be`=4'b1111, `mem_addr`=0x100, no error.
- `rst_n` low during ACCESS → strobes drop same cycle, no `resp_valid` after release, next request serviced normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one aligned byte/half/word access at a time toward a byte-enabled data memory.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of being aligned.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        we_q;

  logic [1:0]  off_n;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic        illegal;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Effective lane offset: halfwords keep addr[1] only, words always use lane 0.
  always_comb begin
    off_n   = 2'b00;
    be_n    = 4'b1111;
    wd_n    = req_wdata;
    illegal = 1'b0;
    case (req_size)
      2'd0: begin
        off_n = req_addr[1:0];
        be_n  = 4'b0001 << req_addr[1:0];
        wd_n  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        off_n = {req_addr[1], 1'b0};
        be_n  = 4'b0011 << {req_addr[1], 1'b0};
        wd_n  = {2{req_wdata[15:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
        illegal = req_addr[0];
`endif
      end
      2'd2: begin
`ifdef LSU_MISALIGN_TRAP_EN
        illegal = (req_addr[1:0] != 2'b00);
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q    <= req_size;
            off_q     <= off_n;
            uns_q     <= req_unsigned;
            we_q      <= req_we;
            req_ready <= 1'b0;
            cnt       <= 8'd0;
            if (illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_read  <= !req_we;
              mem_write <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over the watchdog when both land in the same cycle.
          if (mem_ack || cnt == LIMIT) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !mem_ack;
            resp_rdata <= (mem_ack && !we_q) ? load_data : 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: expected responses queued at request time, popped on resp_valid.
module tb_riscv_lsu;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_write, mem_read, mem_ack;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h @%0t", tag, got, exp, $time);
  endtask

  // Response monitor: every resp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // k: cycle (after handshake) carrying the ack; 0 = illegal (no strobe), -1 = never ack.
  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] mrdata, input int k,
                      input logic [3:0] ebe, input logic [31:0] ewdata,
                      input logic eerr, input logic [31:0] erdata);
    exp_t e;
    int   last;
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    e.err = eerr; e.rdata = erdata;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (k == 0) begin
      @(negedge clk);
      chk("illegal_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
      chk("illegal_resp_t", {31'd0, resp_valid}, 32'd1);
      @(negedge clk);
      chk("illegal_no_strobe2", {30'd0, mem_read, mem_write}, 32'd0);
      chk("ready_after", {31'd0, req_ready}, 32'd1);
      return;
    end
    last = (k < 0) ? T : k;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      chk("mem_read", {31'd0, mem_read}, {31'd0, !we});
      chk("mem_write", {31'd0, mem_write}, {31'd0, we});
      chk("ready_busy", {31'd0, req_ready}, 32'd0);
      if (j == 1) begin
        chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (we) chk("mem_wdata", mem_wdata, ewdata);
      end
      if (j == k) begin
        mem_ack = 1'b1; mem_rdata = mrdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_A5A5;
    end
    @(negedge clk);
    chk("resp_t", {31'd0, resp_valid}, 32'd1);
    chk("strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
    chk("ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'h5A5A_A5A5;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_strobe", {26'd0, mem_be, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80);
    xfer(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 1'b0, 32'h00000080);
    xfer(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234, 32'h0, 4, 4'b1100, 32'h12341234, 1'b0, 32'h0);
    xfer(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, -1, 4'b1111, 32'h0, 1'b1, 32'h0);
    xfer(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, T, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    xfer(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11223344, 0, 4'b0000, 32'h0, 1'b1, 32'h0);
`else
    xfer(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11223344, 1, 4'b1111, 32'h0, 1'b0, 32'h11223344);
`endif
    xfer(1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0);
    xfer(1'b0, 2'd1, 1'b0, 32'h002, 32'h0, 32'h80017FFF, 2, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001);
    xfer(1'b0, 2'd1, 1'b1, 32'h000, 32'h0, 32'h80017FFF, 1, 4'b0011, 32'h0, 1'b0, 32'h00007FFF);
    xfer(1'b1, 2'd0, 1'b0, 32'h001, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0);

    // Reset mid-access: the in-flight load must vanish without a response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_strobe", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    chk("async_rst_be", {28'd0, mem_be}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end
    xfer(1'b0, 2'd0, 1'b0, 32'h000, 32'h0, 32'h0000007F, 1, 4'b0001, 32'h0, 1'b0, 32'h0000007F);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
